// File: rtl/lms_pkg.sv
// Shared constants, controller state encoding and tap-slice helper for the LMS weight bank.
package lms_pkg;

  localparam int NTAP = 15;
  localparam int WW   = 10;
  localparam int CW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Bus bit offset of tap k (taps are numbered from 2).
  function automatic int tap_lsb(input int tap, input int ww);
    return (tap - 2) * ww;
  endfunction

endpackage

// File: rtl/lms_wreg.sv
// One adaptive tap weight: serial-load write has priority over adder-result capture.
module lms_wreg #(
  parameter int WW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en_i,
  input  logic [WW-1:0] ld_data_i,
  input  logic          cap_en_i,
  input  logic [WW-1:0] cap_data_i,
  output logic [WW-1:0] w_o
);

  logic [WW-1:0] w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
    end else if (ld_en_i) begin
      w_q <= ld_data_i;
    end else if (cap_en_i) begin
      w_q <= cap_data_i;
    end
  end

  assign w_o = w_q;

endmodule

// File: rtl/lms_weight_bank.sv
// Tap-weight bank with serial coefficient load and a run/idle controller that
// applies one add/subtract-stage result per sample strobe.
module lms_weight_bank #(
  parameter int NTAP = lms_pkg::NTAP,
  parameter int WW   = lms_pkg::WW,
  parameter int CW   = lms_pkg::CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [WW-1:0]      ld_data,
  output logic               ld_ready,
  output logic               ld_done,
  input  logic               upd_en,
  input  logic               err_sign,
  input  logic               freeze,
  output logic               sg,
  input  logic [NTAP*WW-1:0] n_bus,
  output logic [NTAP*WW-1:0] w_bus,
  output logic               upd_done,
  output logic               upd_drop,
  output logic [CW-1:0]      upd_cnt,
  output logic               busy
);

  import lms_pkg::*;

  localparam int IDXW = (NTAP > 1) ? $clog2(NTAP) : 1;

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic            pend_q;
  logic            sg_q;
  logic            ld_done_q;
  logic            upd_done_q;
  logic            upd_drop_q;
  logic [CW-1:0]   cnt_q;

  logic            ld_wr;
  logic            cap;

  assign ld_wr = (state_q == ST_LOAD) && ld_valid;
  // pend_q is only ever set in RUN, so it alone marks the capture cycle.
  assign cap   = pend_q && !freeze;

  for (genvar i = 0; i < NTAP; i++) begin : g_tap
    localparam int LSB = tap_lsb(i + 2, WW);

    lms_wreg #(.WW(WW)) u_wreg (
      .clk        (clk),
      .rst        (rst),
      .ld_en_i    (ld_wr && (idx_q == IDXW'(i))),
      .ld_data_i  (ld_data),
      .cap_en_i   (cap),
      .cap_data_i (n_bus[LSB +: WW]),
      .w_o        (w_bus[LSB +: WW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      sg_q       <= 1'b0;
      ld_done_q  <= 1'b0;
      upd_done_q <= 1'b0;
      upd_drop_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ld_done_q  <= 1'b0;
      upd_done_q <= 1'b0;
      upd_drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          upd_drop_q <= upd_en;
          if (ld_start) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
          end else if (run_en) begin
            state_q <= ST_RUN;
          end
        end
        ST_LOAD: begin
          upd_drop_q <= upd_en;
          if (ld_valid) begin
            if (idx_q == IDXW'(NTAP - 1)) begin
              state_q   <= ST_IDLE;
              idx_q     <= '0;
              ld_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDXW'(1);
            end
          end
        end
        ST_RUN: begin
          if (pend_q) begin
            // Second update cycle: adder output is valid against the settled sg.
            pend_q     <= 1'b0;
            upd_drop_q <= upd_en;
            if (!freeze) begin
              cnt_q      <= cnt_q + CW'(1);
              upd_done_q <= 1'b1;
            end
          end else if (!run_en) begin
            state_q    <= ST_IDLE;
            upd_drop_q <= upd_en;
          end else if (upd_en) begin
            sg_q   <= err_sign;
            pend_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sg       = sg_q;
  assign ld_ready = (state_q == ST_LOAD);
  assign ld_done  = ld_done_q;
  assign upd_done = upd_done_q;
  assign upd_drop = upd_drop_q;
  assign upd_cnt  = cnt_q;
  assign busy     = (state_q == ST_LOAD) | pend_q;

endmodule

// File: tb/tb_lms_weight_bank.sv
// Randomized bench for lms_weight_bank against an array-based transaction model.
// A narrow update counter is used so the wrap can be reached in a short run.
module tb_lms_weight_bank;

  localparam int NTAP = 15;
  localparam int WW   = 10;
  localparam int CW   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               run_en;
  logic               ld_start;
  logic               ld_valid;
  logic [WW-1:0]      ld_data;
  logic               ld_ready;
  logic               ld_done;
  logic               upd_en;
  logic               err_sign;
  logic               freeze;
  logic               sg;
  logic [NTAP*WW-1:0] n_bus;
  logic [NTAP*WW-1:0] w_bus;
  logic               upd_done;
  logic               upd_drop;
  logic [CW-1:0]      upd_cnt;
  logic               busy;

  always #5 clk = ~clk;

  lms_weight_bank #(.NTAP(NTAP), .WW(WW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_en   (run_en),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .upd_en   (upd_en),
    .err_sign (err_sign),
    .freeze   (freeze),
    .sg       (sg),
    .n_bus    (n_bus),
    .w_bus    (w_bus),
    .upd_done (upd_done),
    .upd_drop (upd_drop),
    .upd_cnt  (upd_cnt),
    .busy     (busy)
  );

  logic [WW-1:0] w_m     [NTAP];
  logic [WW-1:0] ld_vals [NTAP];
  int            cnt_m;
  bit            sg_m;
  int            nvec = 0;
  int            nerr = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NTAP*WW-1:0] pack_m();
    logic [NTAP*WW-1:0] r;
    for (int i = 0; i < NTAP; i++) r[i*WW +: WW] = w_m[i];
    return r;
  endfunction

  function automatic logic [NTAP*WW-1:0] rand_n();
    logic [NTAP*WW-1:0] r;
    for (int i = 0; i < NTAP; i++) r[i*WW +: WW] = WW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NTAP; i++) w_m[i] = '0;
    cnt_m = 0;
    sg_m  = 1'b0;
  endtask

  // Full serial load of ld_vals; gaps inserts an idle cycle before every word.
  task automatic load(input bit gaps);
    int rdy = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < NTAP; k++) begin
      if (gaps) begin
        ld_valid = 1'b0;
        ld_data  = WW'($urandom);
        if (ld_ready) rdy++;
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = ld_vals[k];
      upd_en   = (k == 3);
      ld_start = (k == 5);
      chk("ld_done_early", ld_done, 0);
      if (ld_ready) rdy++;
      tick();
      upd_en   = 1'b0;
      ld_start = 1'b0;
      if (k == 3) chk("ld_upd_drop", upd_drop, 1);
    end
    ld_valid = 1'b0;
    chk("ld_done", ld_done, 1);
    chk("ld_ready_off", ld_ready, 0);
    chk("ld_busy_off", busy, 0);
    chk("ld_ready_cycles", rdy, gaps ? 2 * NTAP : NTAP);
    tick();
    chk("ld_done_pulse", ld_done, 0);
    w_m = ld_vals;
    chk("ld_w_bus", w_bus, pack_m());
  endtask

  // One update request; dbl repeats upd_en in the following cycle.
  task automatic upd(input bit es, input bit frz, input bit dbl, input logic [NTAP*WW-1:0] n);
    n_bus    = n;
    err_sign = es;
    freeze   = frz;
    upd_en   = 1'b1;
    tick();
    upd_en   = dbl;
    err_sign = ~es;
    chk("upd_sg", sg, es);
    chk("upd_busy", busy, 1);
    chk("upd_done_early", upd_done, 0);
    chk("upd_drop_early", upd_drop, 0);
    tick();
    upd_en = 1'b0;
    sg_m   = es;
    if (!frz) begin
      for (int i = 0; i < NTAP; i++) w_m[i] = n[i*WW +: WW];
      cnt_m = (cnt_m + 1) % (1 << CW);
    end
    chk("upd_w_bus", w_bus, pack_m());
    chk("upd_done", upd_done, !frz);
    chk("upd_cnt", upd_cnt, cnt_m);
    chk("upd_drop", upd_drop, dbl);
    chk("upd_busy_off", busy, 0);
    chk("upd_sg_hold", sg, sg_m);
    freeze = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    upd_en = 1'b0; err_sign = 1'b0; freeze = 1'b0; n_bus = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_w_bus", w_bus, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", upd_cnt, 0);
    chk("rst_sg", sg, 0);
    chk("rst_upd_done", upd_done, 0);
    chk("rst_upd_drop", upd_drop, 0);

    // Random contents first, then 1..15 gap-free and with gaps.
    for (int k = 0; k < NTAP; k++) ld_vals[k] = WW'($urandom);
    load(1'b0);
    for (int k = 0; k < NTAP; k++) ld_vals[k] = WW'(k + 1);
    load(1'b0);
    for (int k = 0; k < NTAP; k++) ld_vals[k] = WW'($urandom);
    load(1'b1);
    for (int k = 0; k < NTAP; k++) ld_vals[k] = WW'(k + 1);
    load(1'b1);

    run_en = 1'b1;
    tick();
    chk("run_busy", busy, 0);
    begin
      logic [NTAP*WW-1:0] n5;
      for (int i = 0; i < NTAP; i++) n5[i*WW +: WW] = WW'(5);
      upd(1'b1, 1'b0, 1'b0, n5);
    end
    upd(1'b0, 1'b0, 1'b1, rand_n());
    upd(1'b1, 1'b1, 1'b0, rand_n());
    upd(1'b0, 1'b1, 1'b1, rand_n());
    for (int t = 0; t < 40; t++)
      upd(1'($urandom), ($urandom % 4) == 0, ($urandom % 3) == 0, rand_n());
    while (cnt_m != (1 << CW) - 1)
      upd(1'($urandom), 1'b0, 1'b0, rand_n());
    upd(1'b1, 1'b0, 1'b0, rand_n());
    chk("cnt_wrap", upd_cnt, 0);

    // Leave RUN; sg must hold, and a fresh load then aborted by reset.
    run_en = 1'b0;
    tick();
    chk("idle_sg_hold", sg, sg_m);
    chk("idle_busy", busy, 0);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("abort_ld_ready", ld_ready, 1);
    for (int k = 0; k < 6; k++) begin
      ld_valid = 1'b1;
      ld_data  = WW'($urandom);
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = WW'($urandom);
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    ld_valid = 1'b0;
    model_reset();
    chk("abort_w_bus", w_bus, pack_m());
    chk("abort_ld_ready_off", ld_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", upd_cnt, 0);
    chk("abort_sg", sg, 0);
    chk("abort_ld_done", ld_done, 0);

    for (int k = 0; k < NTAP; k++) ld_vals[k] = WW'($urandom);
    load(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lms_weight_bank.md
Name: lms_weight_bank

Overview:
- Register bank holding the 15 adaptive-filter tap weights (taps 2..16, 10-bit two's complement).
- Sits directly downstream of the 15-lane add/subtract stage:
  - drives the current weights W and the add/subtract select sg into that stage;
  - captures its results N back as the new weights.
- Also provides a serial coefficient-load path and a run/idle controller that sequences one weight update per sample strobe.

Parameters:
- NTAP, 15, number of adaptive taps (taps 2..NTAP+1).
- WW, 10, weight word width in bits.
- CW, 16, width of the update counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- run_en  in  1  level; enables adaptation when in IDLE/RUN.
- ld_start  in  1  pulse; begins a serial load of all NTAP weights (honoured only in IDLE).
- ld_valid  in  1  load word valid.
- ld_data  in  WW  load word, tap order 2 first.
- ld_ready  out  1  high while in LOAD.
- ld_done  out  1  one-cycle pulse after the last load word is written.
- upd_en  in  1  sample strobe requesting one update.
- err_sign  in  1  sign of current error, sampled with upd_en.
- freeze  in  1  level; suppresses weight capture.
- sg  out  1  registered add/sub select to adder stage.
- n_bus  in  NTAP*WW  adder results; tap k at [(k-2)*WW +: WW].
- w_bus  out  NTAP*WW  current weights, same packing.
- upd_done  out  1  one-cycle pulse when an update has been applied.
- upd_drop  out  1  one-cycle pulse when upd_en is discarded.
- upd_cnt  out  CW  count of applied updates, wraps modulo 2^CW.
- busy  out  1  high in LOAD or while an update is pending.

Behaviour:
- Reset values:
  - all weights 0, so w_bus=0;
  - state IDLE, sg=0, pending=0, load index=0;
  - ld_ready=0, ld_done=0, upd_done=0, upd_drop=0, upd_cnt=0, busy=0.
- Reset mid-load or mid-update aborts immediately to the reset state; partial loads are discarded to 0.
- States:
  - IDLE: ld_start -> LOAD with idx=0. Otherwise, if run_en=1 -> RUN. ld_start has priority over run_en.
  - LOAD: ld_ready=1. Each cycle with ld_valid=1, weight[idx] <= ld_data and idx++.
    - When the write at idx=NTAP-1 occurs -> IDLE, with ld_done=1 the next cycle.
    - ld_start and upd_en are ignored in LOAD; upd_en pulses upd_drop.
  - RUN: update sequence when upd_en=1 and pending=0:
    - cycle t: sg <= err_sign, pending <= 1.
    - cycle t+1: sg is stable and the adder's n_bus is valid. If freeze=0, all weights <= n_bus slices simultaneously and upd_cnt++. pending <= 0.
    - cycle t+2: upd_done=1 is visible together with the new w_bus. If freeze=1, no capture, no count, no upd_done.
  - upd_en while pending=1 -> request discarded, upd_drop=1 the next cycle. Maximum sustained rate is one update per 2 cycles.
  - run_en=0 in RUN -> IDLE once pending=0. A pending capture always completes first.
- Arithmetic:
  - Bank performs no arithmetic; n_bus is captured verbatim (wrap behaviour belongs to the adder).
  - upd_cnt wraps from 2^CW-1 to 0.
- sg holds its last value between updates and is not cleared by leaving RUN.
- busy = (state==LOAD) | pending.

Decomposition:
- Shared package (lms_pkg):
  - NTAP, WW constants;
  - state enum {IDLE, LOAD, RUN};
  - tap-slice index function.
- One natural sub-module, lms_wreg: a single WW-bit weight register with load-enable and capture-enable. It is instantiated NTAP times in the bank.
- The FSM, index counter and update counter stay in the top.

Test Plan:
- Reset then load 15 words 1..15 with ld_valid held high -> ld_ready for 15 cycles; ld_done 1 cycle after the 15th; w_bus tap2=1 … tap16=15.
- Load with ld_valid gaps, e.g. valid every other cycle -> only valid cycles write; idx advances correctly; final contents are identical to the gap-free load.
- RUN, n_bus all lanes=0x005, upd_en with err_sign=1 -> sg=1 at t+1; w_bus all 0x005 and upd_done at t+2; upd_cnt=1.
- upd_en on two consecutive cycles -> first applied, second dropped; upd_drop pulses once; upd_cnt increments by 1.
- freeze=1 during an update -> sg updates, but w_bus unchanged, no upd_done, upd_cnt unchanged.
- rst asserted at the 7th load word -> all weights 0, state IDLE, ld_ready=0 next cycle. Also preload upd_cnt=0xFFFF via updates, apply one more update -> upd_cnt=0x0000.
